sd_mem_reader: RTL

Burst read controller for the registered-address two-port memory, on the read clock side. It accepts a (start address, length) command on an srdy/drdy channel and issues one memory read per cycle. It captures the memory output one cycle after each read and streams the words out on an srdy/drdy channel at full throughput under backpressure. It sits between the memory's read port and any downstream sdlib consumer, such as a packet or DMA engine.

---
 rtl/sdlib_mem_pkg.sv | 14 +
 rtl/sd_mem_reader_buf.sv | 46 ++++
 rtl/sd_mem_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sdlib_mem_pkg.sv
// Shared definitions for the sdlib memory reader: FSM state encoding and
// output buffer sizing.
package sdlib_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam int unsigned BUF_DEPTH = 2;
  localparam logic [1:0]  BUF_FULL  = 2'd2;

endpackage

// File: rtl/sd_mem_reader_buf.sv
// Two-entry output FIFO for sd_mem_reader; W carries the data word plus the
// optional last tag.
module sd_mem_reader_buf
  import sdlib_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] entry_r [BUF_DEPTH];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   occ_r;

  // Entry storage, pointers and occupancy; push and pop together leave occ unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        entry_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push) begin
        entry_r[wr_ptr_r] <= push_data;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = entry_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/sd_mem_reader.sv
// Burst read controller for the registered-address memory read port.
// Optional feature macro: SDLIB_MEM_READER_LAST_EN adds the p_last port.
module sd_mem_reader
  import sdlib_mem_pkg::*;
#(
  parameter int width   = 8,
  parameter int depth   = 256,
  parameter int addr_sz = $clog2(depth),
  parameter int len_sz  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [addr_sz-1:0] c_addr,
  input  logic [len_sz-1:0]  c_len,
  output logic               rd_en,
  output logic [addr_sz-1:0] rd_addr,
  input  logic [width-1:0]   mem_d_out,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
`ifdef SDLIB_MEM_READER_LAST_EN
  output logic               p_last,
`endif
  output logic               idle
);

`ifdef SDLIB_MEM_READER_LAST_EN
  localparam int BUF_W = width + 1;
`else
  localparam int BUF_W = width;
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic [addr_sz-1:0] addr_r;
  logic [len_sz-1:0]  rem_r;
  logic               rd_en_r;
  logic [addr_sz-1:0] rd_addr_r;
  logic               mem_vld_r;
  logic               accept_s;
  logic               issue_s;
  logic               c_drdy_s;
  logic               idle_s;
  logic               pop_s;
  logic               push_s;
  logic [1:0]         occ_s;
  logic [1:0]         occ_nxt_s;
  logic               memword_nxt_s;
  logic               credit_ok_s;
  logic [addr_sz-1:0] base_addr_s;
  logic [len_sz-1:0]  base_rem_s;
  logic [BUF_W-1:0]   push_data_s;
  logic [BUF_W-1:0]   head_s;

  function automatic logic [addr_sz-1:0] addr_inc(input logic [addr_sz-1:0] a);
    if (a == addr_sz'(depth - 1)) begin
      return {addr_sz{1'b0}};
    end else begin
      return a + addr_sz'(1);
    end
  endfunction

  assign accept_s  = c_srdy & c_drdy_s;
  assign pop_s     = p_srdy & p_drdy;
  // The memory holds its output until the next read, so a word can wait
  // there while the buffer is full; it is pushed as soon as a slot opens.
  assign push_s        = mem_vld_r & ((occ_s != BUF_FULL) | pop_s);
  assign occ_nxt_s     = occ_s + {1'b0, push_s} - {1'b0, pop_s};
  assign memword_nxt_s = rd_en_r | (mem_vld_r & ~push_s);
  // A new read may overwrite the memory output only once that word is sure to leave it.
  assign credit_ok_s   = ~memword_nxt_s | (occ_nxt_s != BUF_FULL);
  assign base_addr_s   = (state_r == IDLE) ? c_addr : addr_r;
  assign base_rem_s    = (state_r == IDLE) ? c_len  : rem_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (c_len != {len_sz{1'b0}})) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if ((rem_r == {len_sz{1'b0}}) || (issue_s && (rem_r == len_sz'(1)))) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (!rd_en_r && !mem_vld_r && (occ_nxt_s == 2'd0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs; the first read is launched in the accept cycle itself.
  always_comb begin
    c_drdy_s = 1'b0;
    idle_s   = 1'b0;
    issue_s  = 1'b0;
    case (state_r)
      IDLE: begin
        c_drdy_s = 1'b1;
        idle_s   = (occ_s == 2'd0);
        issue_s  = accept_s & (c_len != {len_sz{1'b0}}) & credit_ok_s;
      end
      READ: begin
        issue_s = (rem_r != {len_sz{1'b0}}) & credit_ok_s;
      end
      DRAIN: begin
        issue_s = 1'b0;
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Read issue datapath: registered read port, burst address and remaining count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r    <= {addr_sz{1'b0}};
      rem_r     <= {len_sz{1'b0}};
      rd_en_r   <= 1'b0;
      rd_addr_r <= {addr_sz{1'b0}};
      mem_vld_r <= 1'b0;
    end else begin
      rd_en_r   <= issue_s;
      mem_vld_r <= memword_nxt_s;
      if (issue_s) begin
        rd_addr_r <= base_addr_s;
        addr_r    <= addr_inc(base_addr_s);
        rem_r     <= base_rem_s - len_sz'(1);
      end else if (accept_s) begin
        addr_r <= c_addr;
        rem_r  <= c_len;
      end
    end
  end

`ifdef SDLIB_MEM_READER_LAST_EN
  logic last_rd_r;
  logic last_mem_r;

  // Last-word tag follows its read through the memory output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_rd_r  <= 1'b0;
      last_mem_r <= 1'b0;
    end else begin
      if (issue_s) begin
        last_rd_r <= (base_rem_s == len_sz'(1));
      end
      if (rd_en_r) begin
        last_mem_r <= last_rd_r;
      end
    end
  end

  assign push_data_s      = {last_mem_r, mem_d_out};
  assign {p_last, p_data} = head_s;
`else
  assign push_data_s = mem_d_out;
  assign p_data      = head_s;
`endif

  sd_mem_reader_buf #(
    .W (BUF_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .occ       (occ_s)
  );

  assign c_drdy  = c_drdy_s;
  assign idle    = idle_s;
  assign rd_en   = rd_en_r;
  assign rd_addr = rd_addr_r;
  assign p_srdy  = (occ_s != 2'd0);

endmodule
